// File: rtl/alu_16bit.sv
// 16-bit registered ALU: 16 operations on (imm ? imm_val : a) and b, with result and 8-bit status captured together.
// Define ALU16_MUL_EN to enable the func 11 multiplier; when undefined, func 11 returns zero.
module alu_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm_val,
    input  logic             imm,
    input  logic [3:0]       func,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       status_reg
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_XOR  = 4'd3;
    localparam logic [3:0] F_NOT  = 4'd4;
    localparam logic [3:0] F_OR   = 4'd5;
    localparam logic [3:0] F_SHL  = 4'd6;
    localparam logic [3:0] F_SHR  = 4'd7;
    localparam logic [3:0] F_ASR  = 4'd8;
    localparam logic [3:0] F_ROL  = 4'd9;
    localparam logic [3:0] F_ROR  = 4'd10;
    localparam logic [3:0] F_MUL  = 4'd11;
    localparam logic [3:0] F_PSA  = 4'd12;
    localparam logic [3:0] F_PSB  = 4'd13;
    localparam logic [3:0] F_INC  = 4'd14;
    localparam logic [3:0] F_DEC  = 4'd15;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SHW-1:0]   amt;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH:0]   shr_full;
    logic [WIDTH:0]   asr_full;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] ror_res;
`ifdef ALU16_MUL_EN
    logic [2*WIDTH-1:0] mul_full;
`endif

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic [7:0]       status_c;

    assign opa = imm ? imm_val : a;
    assign opb = b;
    assign amt = opb[SHW-1:0];

    // Extended datapaths: the extra bit of each shift holds the last bit shifted out.
    always_comb begin
        add_full = {1'b0, opa} + {1'b0, opb};
        sub_full = {1'b0, opa} - {1'b0, opb};
        shl_full = {1'b0, opa} << amt;
        shr_full = {opa, 1'b0} >> amt;
        asr_full = (WIDTH+1)'($signed({opa, 1'b0}) >>> amt);
        rol_res  = (opa << amt) | (opa >> (WIDTH - 32'(amt)));
        ror_res  = (opa >> amt) | (opa << (WIDTH - 32'(amt)));
`ifdef ALU16_MUL_EN
        mul_full = (2*WIDTH)'(opa) * (2*WIDTH)'(opb);
`endif
    end

    // Result select with per-operation carry and overflow.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        unique case (func)
            F_ADD: begin
                res_c   = add_full[WIDTH-1:0];
                carry_c = add_full[WIDTH];
                ovf_c   = (opa[WIDTH-1] == opb[WIDTH-1]) && (res_c[WIDTH-1] != opa[WIDTH-1]);
            end
            F_SUB: begin
                res_c   = sub_full[WIDTH-1:0];
                carry_c = sub_full[WIDTH];
                ovf_c   = (opa[WIDTH-1] != opb[WIDTH-1]) && (res_c[WIDTH-1] != opa[WIDTH-1]);
            end
            F_AND: res_c = opa & opb;
            F_XOR: res_c = opa ^ opb;
            F_NOT: res_c = ~opa;
            F_OR:  res_c = opa | opb;
            F_SHL: begin
                res_c   = shl_full[WIDTH-1:0];
                carry_c = shl_full[WIDTH];
            end
            F_SHR: begin
                res_c   = shr_full[WIDTH:1];
                carry_c = shr_full[0];
            end
            F_ASR: begin
                res_c   = asr_full[WIDTH:1];
                carry_c = asr_full[0];
            end
            F_ROL: begin
                res_c   = rol_res;
                carry_c = (amt != '0) && rol_res[0];
            end
            F_ROR: begin
                res_c   = ror_res;
                carry_c = (amt != '0) && ror_res[WIDTH-1];
            end
            F_MUL: begin
`ifdef ALU16_MUL_EN
                res_c   = mul_full[WIDTH-1:0];
                carry_c = |mul_full[2*WIDTH-1:WIDTH];
`else
                res_c   = '0;
                carry_c = 1'b0;
`endif
            end
            F_PSA: res_c = opa;
            F_PSB: res_c = opb;
            F_INC: begin
                res_c   = opa + WIDTH'(1);
                carry_c = &opa;
                ovf_c   = (opa == {1'b0, {(WIDTH-1){1'b1}}});
            end
            F_DEC: begin
                res_c   = opa - WIDTH'(1);
                carry_c = (opa == '0);
                ovf_c   = (opa == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: res_c = '0;
        endcase
    end

    always_comb begin
        status_c[0] = (res_c == '0);
        status_c[1] = carry_c;
        status_c[2] = res_c[WIDTH-1];
        status_c[3] = ovf_c;
        status_c[4] = (opa == opb);
        status_c[5] = (opa > opb);
        status_c[6] = (opa < opb);
        status_c[7] = ($signed(opa) < $signed(opb));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= '0;
            status_reg <= '0;
        end else begin
            out        <= res_c;
            status_reg <= status_c;
        end
    end

endmodule

// File: tb/tb_alu_16bit.sv
// Directed vector bench for alu_16bit: table of hand-computed results plus reset sequences.
module tb_alu_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm_val;
    logic        imm;
    logic [3:0]  func;
    logic [15:0] out;
    logic [7:0]  status_reg;

    int n_applied = 0;
    int n_miss    = 0;

    alu_16bit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .imm_val    (imm_val),
        .imm        (imm),
        .func       (func),
        .out        (out),
        .status_reg (status_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        imm;
        logic [15:0] imm_val;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  func;
        logic [15:0] exp_out;
        logic [7:0]  exp_st;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs[NVEC];

`ifdef ALU16_MUL_EN
    localparam logic [7:0] MUL_ST = 8'h13;
`else
    localparam logic [7:0] MUL_ST = 8'h11;
`endif

    function automatic vec_t mk(string nm, logic im, logic [15:0] iv, logic [15:0] va,
                                logic [15:0] vb, logic [3:0] fn, logic [15:0] eo, logic [7:0] es);
        vec_t v;
        v.name = nm; v.imm = im; v.imm_val = iv; v.a = va; v.b = vb;
        v.func = fn; v.exp_out = eo; v.exp_st = es;
        return v;
    endfunction

    task automatic chk_out(string nm, logic [15:0] exp_o, logic [7:0] exp_s);
        if (out !== exp_o) begin
            n_miss++;
            $display("FAIL %s out: got %h expected %h", nm, out, exp_o);
        end
        if (status_reg !== exp_s) begin
            n_miss++;
            $display("FAIL %s status_reg: got %h expected %h", nm, status_reg, exp_s);
        end
    endtask

    task automatic drive(logic im, logic [15:0] iv, logic [15:0] va, logic [15:0] vb, logic [3:0] fn);
        imm = im; imm_val = iv; a = va; b = vb; func = fn;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("add_gtu",    1'b0, 16'h0000, 16'h0004, 16'h0003, 4'd0,  16'h0007, 8'h20);
        vecs[1]  = mk("add_eq",     1'b0, 16'h0000, 16'h0005, 16'h0005, 4'd0,  16'h000A, 8'h10);
        vecs[2]  = mk("add_ltu",    1'b0, 16'h0000, 16'h0002, 16'h0006, 4'd0,  16'h0008, 8'hC0);
        vecs[3]  = mk("imm_add",    1'b1, 16'h1200, 16'h0000, 16'h0000, 4'd0,  16'h1200, 8'h20);
        vecs[4]  = mk("imm_or",     1'b1, 16'h0034, 16'h0000, 16'h1200, 4'd5,  16'h1234, 8'hC0);
        vecs[5]  = mk("sub_borrow", 1'b0, 16'h0000, 16'h0000, 16'h0001, 4'd1,  16'hFFFF, 8'hC6);
        vecs[6]  = mk("add_ovf",    1'b0, 16'h0000, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 8'h2C);
        vecs[7]  = mk("shl_c",      1'b0, 16'h0000, 16'h8001, 16'h0001, 4'd6,  16'h0002, 8'hA2);
        vecs[8]  = mk("asr4",       1'b0, 16'h0000, 16'h8000, 16'h0004, 4'd8,  16'hF800, 8'hA4);
        vecs[9]  = mk("ror1",       1'b0, 16'h0000, 16'h0001, 16'h0001, 4'd10, 16'h8000, 8'h16);
        vecs[10] = mk("mul",        1'b0, 16'h0000, 16'h0100, 16'h0100, 4'd11, 16'h0000, MUL_ST);
        vecs[11] = mk("dec_zero",   1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd15, 16'hFFFF, 8'h16);
        vecs[12] = mk("inc_wrap",   1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd14, 16'h0000, 8'hA3);
        vecs[13] = mk("inc_ovf",    1'b0, 16'h0000, 16'h7FFF, 16'h7FFF, 4'd14, 16'h8000, 8'h1C);
        vecs[14] = mk("sub_ovf",    1'b0, 16'h0000, 16'h8000, 16'h0001, 4'd1,  16'h7FFF, 8'hA8);
        vecs[15] = mk("shr_c",      1'b0, 16'h0000, 16'h0003, 16'h0001, 4'd7,  16'h0001, 8'h22);
        vecs[16] = mk("shl_amt0",   1'b0, 16'h0000, 16'hFFFF, 16'h0010, 4'd6,  16'hFFFF, 8'hA4);
        vecs[17] = mk("rol1",       1'b0, 16'h0000, 16'h8000, 16'h0001, 4'd9,  16'h0001, 8'hA2);
        vecs[18] = mk("xor_zero",   1'b0, 16'h0000, 16'h00FF, 16'h00FF, 4'd3,  16'h0000, 8'h11);
        vecs[19] = mk("not",        1'b0, 16'h0000, 16'h0F0F, 16'hF0F0, 4'd4,  16'hF0F0, 8'h44);
        vecs[20] = mk("and",        1'b0, 16'h0000, 16'hFF00, 16'h0FF0, 4'd2,  16'h0F00, 8'hA0);
        vecs[21] = mk("pass_a",     1'b0, 16'hFFFF, 16'h1234, 16'h0000, 4'd12, 16'h1234, 8'h20);
        vecs[22] = mk("pass_b",     1'b0, 16'h0000, 16'h0000, 16'h8765, 4'd13, 16'h8765, 8'h44);
        vecs[23] = mk("asr_amt0",   1'b0, 16'h0000, 16'h8000, 16'h0000, 4'd8,  16'h8000, 8'hA4);
        vecs[24] = mk("add_carry",  1'b0, 16'h0000, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 8'hA3);

        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0004, 16'h0003, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        n_applied++;
        chk_out("reset_state", 16'h0000, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        // Each vector is driven mid-cycle and read 1 time unit after the capturing edge.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].imm, vecs[i].imm_val, vecs[i].a, vecs[i].b, vecs[i].func);
            @(posedge clk);
            #1;
            n_applied++;
            chk_out(vecs[i].name, vecs[i].exp_out, vecs[i].exp_st);
            @(negedge clk);
        end

        // Result must not move before the next edge.
        drive(1'b0, 16'h0000, 16'h0001, 16'h0001, 4'd0);
        #1;
        n_applied++;
        chk_out("latency_hold", 16'h0000, 8'hA3);
        @(posedge clk);
        #1;
        n_applied++;
        chk_out("add_1_1", 16'h0002, 8'h10);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        n_applied++;
        chk_out("async_reset", 16'h0000, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        n_applied++;
        chk_out("reset_held", 16'h0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_applied++;
        chk_out("release_no_edge", 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        n_applied++;
        chk_out("first_after_release", 16'h0002, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_16bit.md
Name: alu_16bit

Overview:
16-bit registered ALU for the micro-CPU datapath. It takes two register operands, or an immediate in place of operand A, and applies one of 16 operations. Result and an 8-bit status register are captured on the rising clock edge. It sits between the register file/decoder and the writeback path; status feeds branch logic.

Parameters:
WIDTH, 16, datapath width (all arithmetic rules below are stated for 16).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a  input  16  operand register A
b  input  16  operand register B
imm_val  input  16  immediate value
imm  input  1  1 = use imm_val as operand A
func  input  4  operation select
out  output  16  registered result
status_reg  output  8  registered flags

Behaviour:
- Effective operands: OPA = imm ? imm_val : a; OPB = b (always).
- Combinational result R from func:
  - 0 ADD OPA+OPB; 1 SUB OPA-OPB; 2 AND; 3 XOR; 4 NOT OPA; 5 OR.
  - 6 SHL OPA<<OPB[3:0]; 7 SHR logical; 8 ASR (arithmetic); 9 ROL by OPB[3:0]; 10 ROR by OPB[3:0].
  - 11 MUL low 16 bits (see Optional Feature).
  - 12 PASS OPA; 13 PASS OPB; 14 INC OPA+1; 15 DEC OPA-1.
- All arithmetic is modulo 2^16.
- Flags computed from R and operands, all registered together with out:
  - [0] Z: R==0.
  - [1] C: ADD/INC carry-out. SUB/DEC borrow (OPA<OPB unsigned; DEC: OPA==0). Shifts/rotates: last bit shifted out, 0 if amount==0. All other funcs: 0.
  - [2] N: R[15].
  - [3] V: signed overflow for ADD/SUB/INC/DEC; 0 otherwise.
  - [4] EQ: OPA==OPB.
  - [5] GTU: OPA>OPB unsigned.
  - [6] LTU: OPA<OPB unsigned.
  - [7] LTS: OPA<OPB signed.
- EQ/GTU/LTU/LTS update every cycle regardless of func; exactly one of EQ/GTU/LTU is 1.
- Latency: one cycle. Inputs sampled at edge k appear on out/status_reg after edge k. No handshake; updates every cycle.
- Reset: rst_n low asynchronously forces out=0x0000 and status_reg=0x00 immediately. Both are held while rst_n is low. The first capture occurs on the first rising edge after release. Reset mid-operation discards the pending result.
- X/undefined inputs are not handled specially.

Optional Feature:
- Macro ALU16_MUL_EN.
- Defined: func 11 yields low 16 bits of the unsigned OPA*OPB; C=1 if the high 16 bits are nonzero; V=0.
- Undefined: func 11 yields R=0x0000, C=0, V=0; Z=1; compare flags as normal.

Test Plan:
- imm=0, func=0, a=4, b=3 -> next edge: out=7, status_reg=0x20 (GTU). Then a=5, b=5 -> out=10, status_reg=0x10 (EQ). Then a=2, b=6 -> out=8, status_reg=0xC0 (LTU, LTS).
- imm=1, imm_val=0x1200, func=0, a=0, b=0 -> out=0x1200. Then imm_val=0x0034, func=5, b=0x1200 -> out=0x1234.
- func=1, a=0, b=1 -> out=0xFFFF; Z=0, C=1, N=1, V=0; LTU=1. func=0, a=0x7FFF, b=1 -> out=0x8000; N=1, V=1, C=0.
- func=6, a=0x8001, b=1 -> out=0x0002, C=1. func=8, a=0x8000, b=4 -> out=0xF800. func=10, a=0x0001, b=1 -> out=0x8000, C=1.
- func=11, a=0x0100, b=0x0100 -> with ALU16_MUL_EN: out=0x0000, C=1, Z=1. Without it: out=0x0000, C=0.
- Drive func=0, a=1, b=1. Assert rst_n low between edges -> out/status_reg go to 0 immediately without a clock edge. They stay 0 until rst_n is released, then read out=2 after the next edge.
